nibble_serializer: RTL

//  Downstream of the 4-bit parallel/serial register: takes the held nibble and transmits it as one UART-style frame on a single line.

---
 rtl/serializer_pkg.sv | 17 +
 rtl/bit_timer.sv | 29 ++
 rtl/nibble_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared types and line levels for the nibble serializer.
// Frame states plus the fixed levels driven on the serial line.
package serializer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } ser_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Counts clk_2 cycles within one frame bit and flags the last cycle of each bit.
// With CLKS_PER_BIT=1 the counter is pinned at zero, so bit_end is high every cycle.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk_2,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TERM = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count;

  assign bit_end = (count == TERM);

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/nibble_serializer.sv
// Sends a latched nibble as one frame: start(0), data LSB-first, optional even parity, stop(1).
// The line and status outputs are registered or pure state decode, so valid_in never reaches serial_out combinationally.
module nibble_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned NBITS_DATA   = 4,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic [NBITS_DATA-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  serial_out,
  output logic                  busy,
  output logic [2:0]            bit_idx,
  output logic                  done
);

  localparam int CW = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS_DATA - 1);

  ser_state_t            state;
  logic [NBITS_DATA-1:0] shreg;
  logic [NBITS_DATA-1:0] shreg_next;
  logic                  parity;
  logic [CW-1:0]         bit_cnt;
  logic                  bit_end;
  logic                  accept;
  logic                  leave_state;
  logic                  timer_clear;

  assign ready_out  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign bit_idx    = 3'(bit_cnt);
  assign accept     = ready_out && valid_in;
  assign shreg_next = shreg >> 1;

  // Every busy state ends on bit_end, except DATA which only leaves after its last bit.
  assign leave_state = busy && bit_end && !((state == S_DATA) && (bit_cnt != LAST_BIT));
  assign timer_clear = accept || leave_state;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_2  (clk_2),
    .reset  (reset),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  // serial_out is loaded with the level of the state being entered, so it changes on the same edge as state.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      serial_out <= LINE_IDLE;
      done       <= 1'b0;
      shreg      <= '0;
      parity     <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          serial_out <= LINE_IDLE;
          if (valid_in) begin
            shreg      <= data_in;
            parity     <= ^data_in;
            bit_cnt    <= '0;
            serial_out <= START_BIT;
            state      <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            serial_out <= shreg[0];
            state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg <= shreg_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                serial_out <= parity;
                state      <= S_PARITY;
              end else begin
                serial_out <= STOP_BIT;
                state      <= S_STOP;
              end
            end else begin
              bit_cnt    <= bit_cnt + CW'(1);
              serial_out <= shreg_next[0];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            serial_out <= STOP_BIT;
            state      <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            serial_out <= LINE_IDLE;
            done       <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          serial_out <= LINE_IDLE;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
